// File: rtl/rom_writer.sv
// rom_writer: programs a 32-bit instruction word into four byte-lane AT28C256 EEPROMs with DATA polling
module rom_writer #(
    parameter int WE_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_flag,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [12:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        done,
    output logic        err,
    output logic [14:0] rom_addr,
    output logic [7:0]  rom_dq_out,
    output logic        rom_dq_oe,
    input  logic [7:0]  rom_dq_in,
    output logic [3:0]  rom_ce_n,
    output logic [3:0]  rom_we_n,
    output logic [3:0]  rom_oe_n
);
    localparam int CMAX = (WE_CYCLES > TIMEOUT_CYCLES) ? WE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, POLL, NEXT} state_t;

    state_t        state, state_d;
    logic [1:0]    lane, lane_d;
    logic [12:0]   addr, addr_d;
    logic [31:0]   data, data_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          err_d, done_d, ready_d, dq_oe_d;
    logic [7:0]    cur, dq_out_d;
    logic [3:0]    lane_sel, ce_n_d, we_n_d, oe_n_d;
    logic          unused_dq;

    assign cur       = data[{lane, 3'b000} +: 8];
    assign unused_dq = ^rom_dq_in[6:0];

    // sequencing, plus the output values that belong to the state being entered so every pin is a flop
    always_comb begin
        state_d = state;
        lane_d  = lane;
        addr_d  = addr;
        data_d  = data;
        cnt_d   = cnt + 1'b1;
        err_d   = err;
        case (state)
            IDLE: begin
                cnt_d = cnt;
                if (wr_valid && wr_ready) begin
                    state_d = SETUP;
                    lane_d  = 2'd0;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: state_d = (cnt == CW'(WE_CYCLES - 1)) ? HOLD : PULSE;
            HOLD: begin
                state_d = POLL;
                cnt_d   = '0;
            end
            POLL: begin
                if (cnt != '0 && rom_dq_in[7] == cur[7]) begin
                    state_d = NEXT;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            NEXT: begin
                state_d = (lane == 2'd3) ? IDLE : SETUP;
                lane_d  = (lane == 2'd3) ? lane : lane + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        lane_sel = 4'b0001 << lane_d;
        ready_d  = state_d == IDLE;
        done_d   = state_d == NEXT && lane_d == 2'd3;
        dq_oe_d  = state_d inside {SETUP, PULSE, HOLD};
        ce_n_d   = (dq_oe_d || state_d == POLL) ? ~lane_sel : 4'hF;
        we_n_d   = (state_d == PULSE) ? ~lane_sel : 4'hF;
        oe_n_d   = (state_d == POLL) ? ~lane_sel : 4'hF;
        dq_out_d = data_d[{lane_d, 3'b000} +: 8];
    end

    // state, request latch and registered EEPROM bus; reset releases every chip at once
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state      <= IDLE;
            lane       <= '0;
            addr       <= '0;
            data       <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b1;
            rom_addr   <= '0;
            rom_dq_out <= '0;
            rom_dq_oe  <= 1'b0;
            rom_ce_n   <= 4'hF;
            rom_we_n   <= 4'hF;
            rom_oe_n   <= 4'hF;
        end else begin
            state      <= state_d;
            lane       <= lane_d;
            addr       <= addr_d;
            data       <= data_d;
            cnt        <= cnt_d;
            err        <= err_d;
            done       <= done_d;
            wr_ready   <= ready_d;
            rom_addr   <= {addr_d, lane_d};
            rom_dq_out <= dq_out_d;
            rom_dq_oe  <= dq_oe_d;
            rom_ce_n   <= ce_n_d;
            rom_we_n   <= we_n_d;
            rom_oe_n   <= oe_n_d;
        end
    end
endmodule

// File: tb/tb_rom_writer.sv
// tb_rom_writer: directed bench with a per-cycle timeline model and a behavioural EEPROM
module tb_rom_writer;
    localparam int WE  = 4;
    localparam int TO0 = 20000;
    localparam int TO1 = 50;

    typedef struct packed {
        logic [38:0] v;
        logic [38:0] m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_flag = 1'b1;
    logic        wr_valid [2];
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready [2];
    logic        done [2];
    logic        err [2];
    logic        rom_dq_oe [2];
    logic [14:0] rom_addr [2];
    logic [7:0]  rom_dq_out [2];
    logic [7:0]  rom_dq_in [2];
    logic [3:0]  rom_ce_n [2];
    logic [3:0]  rom_we_n [2];
    logic [3:0]  rom_oe_n [2];

    rom_writer u0 (
        .clk(clk), .rst_flag(rst_flag), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
        .wr_addr(wr_addr), .wr_data(wr_data), .done(done[0]), .err(err[0]),
        .rom_addr(rom_addr[0]), .rom_dq_out(rom_dq_out[0]), .rom_dq_oe(rom_dq_oe[0]),
        .rom_dq_in(rom_dq_in[0]), .rom_ce_n(rom_ce_n[0]), .rom_we_n(rom_we_n[0]), .rom_oe_n(rom_oe_n[0])
    );

    rom_writer #(.TIMEOUT_CYCLES(TO1)) u1 (
        .clk(clk), .rst_flag(rst_flag), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
        .wr_addr(wr_addr), .wr_data(wr_data), .done(done[1]), .err(err[1]),
        .rom_addr(rom_addr[1]), .rom_dq_out(rom_dq_out[1]), .rom_dq_oe(rom_dq_oe[1]),
        .rom_dq_in(rom_dq_in[1]), .rom_ce_n(rom_ce_n[1]), .rom_we_n(rom_we_n[1]), .rom_oe_n(rom_oe_n[1])
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mem [4][32768];
    bit          mem_init = 1'b0;
    logic [3:0]  wlow [2] = '{4'h0, 4'h0};
    int          pcnt [2] = '{0, 0};
    int          mode = 0;
    int          sel = 0;
    int          poll_len = 2;
    int          fail_lane = 4;
    exp_t        q [$];
    logic        err_exp = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_n = 0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    logic        c3_sel = 1'b0;

    function automatic exp_t mk(logic rdy, logic dn, logic er, logic [3:0] ce, logic [3:0] we, logic [3:0] oe,
                                logic doe, logic [14:0] a, logic [7:0] b, logic ca, logic cb);
        mk.v = {rdy, dn, er, ce, we, oe, doe, a, b};
        mk.m = {16'hFFFF, {15{ca}}, {8{cb}}};
    endfunction

    // Timeline of one word: per lane setup, WE-cycle pulse, hold, poll window, lane gap.
    function automatic void plan(logic [12:0] a, logic [31:0] d, int to);
        logic [3:0]  s;
        logic [14:0] ad;
        logic [7:0]  b;
        int          n;
        for (int l = 0; l < 4; l++) begin
            s  = ~(4'b0001 << l);
            ad = {a, 2'(l)};
            b  = d[8*l +: 8];
            q.push_back(mk(1'b0, 1'b0, 1'b0, s, 4'hF, 4'hF, 1'b1, ad, b, 1'b1, 1'b1));
            repeat (WE) q.push_back(mk(1'b0, 1'b0, 1'b0, s, s, 4'hF, 1'b1, ad, b, 1'b1, 1'b1));
            q.push_back(mk(1'b0, 1'b0, 1'b0, s, 4'hF, 4'hF, 1'b1, ad, b, 1'b1, 1'b1));
            n = (l == fail_lane) ? to : poll_len;
            repeat (n) q.push_back(mk(1'b0, 1'b0, 1'b0, s, 4'hF, s, 1'b0, ad, b, 1'b1, 1'b0));
            if (l == fail_lane) begin
                q.push_back(mk(1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, ad, b, 1'b0, 1'b0));
                return;
            end
            q.push_back(mk(1'b0, l == 3, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, ad, b, 1'b0, 1'b0));
        end
        q.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0));
    endfunction

    function automatic logic [31:0] rd(logic [12:0] a);
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = mem[i][{a, 2'(i)}];
    endfunction

    // Behavioural EEPROM: latches a byte on the first low cycle of we_n, answers polls with bit7.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 32768; j++) mem[i][j] = 8'h00;
            mem_init = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            rom_dq_in[d] = 8'h00;
            for (int i = 0; i < 4; i++) begin
                if (!rom_we_n[d][i] && !wlow[d][i]) mem[i][rom_addr[d]] = rom_dq_out[d];
                wlow[d][i] = !rom_we_n[d][i];
                if (!rom_oe_n[d][i]) begin
                    rom_dq_in[d] = mem[i][rom_addr[d]];
                    if ((mode == 1 && pcnt[d] <= 100) || (mode == 2 && i == 2))
                        rom_dq_in[d][7] = ~rom_dq_in[d][7];
                end
            end
            pcnt[d] = (rom_oe_n[d] != 4'hF && !rst_flag) ? pcnt[d] + 1 : 0;
        end
    end

    // Compare process: every cycle the selected DUT must match the timeline model.
    always @(negedge clk) begin
        exp_t        e;
        logic [38:0] act;
        cyc++;
        if (rst_flag) begin
            q.delete();
            err_exp = 1'b0;
        end
        if (q.size() > 0) e = q.pop_front();
        else e = mk(1'b1, 1'b0, err_exp, 4'hF, 4'hF, 4'hF, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0);
        err_exp = e.v[36];
        act = {wr_ready[sel], done[sel], err[sel], rom_ce_n[sel], rom_we_n[sel], rom_oe_n[sel],
               rom_dq_oe[sel], rom_addr[sel], rom_dq_out[sel]};
        total++;
        if (((act ^ e.v) & e.m) != '0) begin
            bad++;
            $display("FAIL cycle %0d dut%0d: got %h want %h (mask %h)", cyc, sel, act, e.v, e.m);
        end
        if (done[sel]) done_cyc = cyc;
        if (err[sel] && err_cyc < 0) err_cyc = cyc;
        if (!rom_ce_n[sel][3]) c3_sel = 1'b1;
        if (e.v[38] && wr_valid[sel] && !rst_flag) begin
            plan(wr_addr, wr_data, sel ? TO1 : TO0);
            acc_cyc  = cyc;
            acc_n++;
            done_cyc = -1;
            err_cyc  = -1;
            c3_sel   = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic req(input int d, input logic [12:0] a, input logic [31:0] v, input logic keep);
        int n0;
        n0 = acc_n;
        sel = d;
        wr_addr = a;
        wr_data = v;
        wr_valid[d] = 1'b1;
        for (int k = 0; k < 2000 && acc_n == n0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("accept", 32'(acc_n != n0), 32'd1);
        if (!keep) wr_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int k = 0; k < lim && q.size() > 0; k++) @(negedge clk);
        chk("word finished", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc1;
        int found;
        wr_valid[0] = 1'b0;
        wr_valid[1] = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctl u0", 32'({wr_ready[0], done[0], err[0], rom_ce_n[0], rom_we_n[0], rom_oe_n[0], rom_dq_oe[0]}), 32'h9FFE);
        chk("reset bus u0", 32'({rom_addr[0], rom_dq_out[0]}), 32'h0);
        chk("reset ctl u1", 32'({wr_ready[1], done[1], err[1], rom_ce_n[1], rom_we_n[1], rom_oe_n[1], rom_dq_oe[1]}), 32'h9FFE);
        rst_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        req(0, 13'h0005, 32'hDEADBEEF, 1'b0);
        wait_idle(200);
        chk("single latency", done_cyc - acc_cyc, 36);
        chk("single chip0", 32'(mem[0][15'h0014]), 32'hEF);
        chk("single chip1", 32'(mem[1][15'h0015]), 32'hBE);
        chk("single chip2", 32'(mem[2][15'h0016]), 32'hAD);
        chk("single chip3", 32'(mem[3][15'h0017]), 32'hDE);
        chk("single err", 32'(err[0]), 32'h0);

        mode = 1;
        poll_len = 102;
        req(0, 13'h0A5A, 32'h80FF7F00, 1'b0);
        wait_idle(1000);
        chk("slow latency", done_cyc - acc_cyc, 436);
        chk("slow readback", rd(13'h0A5A), 32'h80FF7F00);
        chk("slow err", 32'(err[0]), 32'h0);
        poll_len = 2;

        mode = 2;
        fail_lane = 2;
        req(1, 13'h0123, 32'h89ABCDEF, 1'b0);
        wait_idle(500);
        chk("timeout err latency", err_cyc - acc_cyc, 75);
        chk("timeout err", 32'(err[1]), 32'h1);
        chk("timeout ready", 32'(wr_ready[1]), 32'h1);
        chk("timeout chip3 unselected", 32'(c3_sel), 32'h0);
        chk("timeout no done", done_cyc, -1);
        mode = 0;
        fail_lane = 4;
        req(1, 13'h0124, 32'h00000000, 1'b0);
        chk("err cleared by accept", 32'(err[1]), 32'h0);
        wait_idle(200);

        req(0, 13'h1FFF, 32'h01020304, 1'b0);
        wait_idle(200);
        chk("boundary chip0", 32'(mem[0][15'h7FFC]), 32'h04);
        chk("boundary chip3", 32'(mem[3][15'h7FFF]), 32'h01);
        chk("boundary word", rd(13'h1FFF), 32'h01020304);
        chk("boundary no wrap", rd(13'h0000), 32'h0);

        req(0, 13'h0200, 32'h55AA55AA, 1'b0);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clk);
            if (!rom_we_n[0][1]) found = 1;
        end
        chk("pulse on chip1 seen", found, 1);
        @(posedge clk);
        #3;
        rst_flag = 1'b1;
        #1;
        chk("async reset strobes", 32'({rom_ce_n[0], rom_we_n[0], rom_oe_n[0]}), 32'hFFF);
        chk("async reset ctl", 32'({wr_ready[0], done[0], rom_dq_oe[0]}), 32'h4);
        @(posedge clk);
        #1;
        rst_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        req(0, 13'h0100, 32'h11223344, 1'b1);
        acc1 = acc_cyc;
        req(0, 13'h0101, 32'hCAFEF00D, 1'b0);
        chk("back-to-back spacing", acc_cyc - acc1, 37);
        wait_idle(200);
        chk("b2b word0", rd(13'h0100), 32'h11223344);
        chk("b2b word1", rd(13'h0101), 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
